// File: rtl/neuron_slot_demux_if.sv
// Bus bundle for the neuron slot demultiplexer.
// The master side drives the frame strobe, the multiplexed data and the
// neuron selection. The slave side (the demux) returns the captured value,
// the capture pulse and the alignment status.
interface neuron_slot_demux_if #(
  parameter int NN = 8,
  parameter int DW = 32
) ();

  logic              frame_strobe;
  logic [DW-1:0]     data_in;
  logic [NN:0]       sel_index;
  logic [1:0]        sel_phase;

  logic [DW-1:0]     cap_data;
  logic              cap_valid;
  logic              locked;
  logic [7:0]        sync_err_cnt;
  logic [NN+2:0]     slot_cnt_out;

  // Producer of the multiplexed stream and of the selection.
  modport master (
    output frame_strobe,
    output data_in,
    output sel_index,
    output sel_phase,
    input  cap_data,
    input  cap_valid,
    input  locked,
    input  sync_err_cnt,
    input  slot_cnt_out
  );

  // The demultiplexer itself.
  modport slave (
    input  frame_strobe,
    input  data_in,
    input  sel_index,
    input  sel_phase,
    output cap_data,
    output cap_valid,
    output locked,
    output sync_err_cnt,
    output slot_cnt_out
  );

endinterface

// File: rtl/neuron_slot_demux.sv
// Neuron slot demultiplexer.
// A frame carries 2^(NN+1) neurons, each occupying four consecutive cycles,
// so a frame is 2^(NN+3) cycles long and a slot value is {neuron, phase}.
// The block aligns a local slot counter to frame_strobe, tracks sync errors,
// and captures the data word at the selected {neuron, phase} once per frame.
module neuron_slot_demux #(
  parameter int NN = 8,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  neuron_slot_demux_if.slave   bus
);

  localparam int CW = NN + 3;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;

  logic [NN:0]     sh_index_q;
  logic [NN:0]     sh_index_d;
  logic [1:0]      sh_phase_q;
  logic [1:0]      sh_phase_d;

  logic            captured_q;
  logic            captured_d;

  logic [7:0]      err_q;
  logic [7:0]      err_d;

  logic [DW-1:0]   cap_data_q;
  logic            cap_valid_q;

  logic [CW-1:0]   cur_slot;
  logic [NN:0]     eff_index;
  logic [1:0]      eff_phase;
  logic            align;
  logic            sync_err;
  logic            capture_ok;
  logic            capture;

  // Next-state, slot tracking, shadow selection and capture decision.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_index_d = sh_index_q;
    sh_phase_d = sh_phase_q;
    captured_d = captured_q;
    err_d      = err_q;
    eff_index  = sh_index_q;
    eff_phase  = sh_phase_q;
    align      = 1'b0;
    sync_err   = 1'b0;
    capture_ok = 1'b0;
    capture    = 1'b0;

    // A strobe always marks slot 0 of the current cycle.
    cur_slot = bus.frame_strobe ? '0 : cnt_q;

    case (state_q)
      HUNT: begin
        if (bus.frame_strobe) begin
          align   = 1'b1;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (bus.frame_strobe) begin
          align = 1'b1;
          if (cnt_q != '0) begin
            sync_err = 1'b1;
          end
        end else if (cnt_q == '0) begin
          sync_err = 1'b1;
          state_d  = HUNT;
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase

    // An accepted slot 0 restarts the frame and takes the new selection
    // immediately, so a slot-0 selection can capture on this very cycle.
    if (align) begin
      eff_index  = bus.sel_index;
      eff_phase  = bus.sel_phase;
      sh_index_d = bus.sel_index;
      sh_phase_d = bus.sel_phase;
      cnt_d      = CW'(1);
    end else if (state_d == HUNT) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // The missing-strobe cycle drops to HUNT and therefore never captures.
    capture_ok = align |
                 ((state_q == LOCKED) && (state_d == LOCKED) && !captured_q);
    capture    = capture_ok && (cur_slot == {eff_index, eff_phase});

    if (align) begin
      captured_d = capture;
    end else if (state_d == HUNT) begin
      captured_d = 1'b0;
    end else begin
      captured_d = captured_q | capture;
    end

    if (sync_err && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  // State, counter, shadow selection, error count and capture registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      sh_index_q  <= '0;
      sh_phase_q  <= '0;
      captured_q  <= 1'b0;
      err_q       <= '0;
      cap_data_q  <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_index_q  <= sh_index_d;
      sh_phase_q  <= sh_phase_d;
      captured_q  <= captured_d;
      err_q       <= err_d;
      cap_valid_q <= capture;
      if (capture) begin
        cap_data_q <= bus.data_in;
      end
    end
  end

  assign bus.cap_data     = cap_data_q;
  assign bus.cap_valid    = cap_valid_q;
  assign bus.locked       = (state_q == LOCKED);
  assign bus.sync_err_cnt = err_q;
  assign bus.slot_cnt_out = cnt_q;

endmodule

// File: tb/tb_neuron_slot_demux.sv
// Directed bench for neuron_slot_demux with NN=2 (8 neurons, 32-cycle frame).
// Inputs change 1 time unit after each rising edge; outputs are checked at
// the same point, so they reflect the edge that just happened.
module tb_neuron_slot_demux;

  localparam int NN = 2;
  localparam int DW = 32;

  logic clk;
  logic reset_n;

  int n_tests;
  int n_fail;

  int          v_cnt;
  int          v_slot;
  logic [31:0] v_data;

  neuron_slot_demux_if #(.NN(NN), .DW(DW)) bus ();

  neuron_slot_demux #(.NN(NN), .DW(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of stimulus and step past the next rising edge.
  task automatic apply_stimulus(input logic strobe, input logic [31:0] data);
    bus.frame_strobe = strobe;
    bus.data_in      = data;
    @(posedge clk);
    #1;
  endtask

  // Drive slots first..last with data = base + slot, strobing on the first
  // one if asked, and record how many captures appeared and where.
  task automatic run_slots(input int first, input int last,
                           input bit strobe_first, input logic [31:0] base);
    v_cnt  = 0;
    v_slot = -1;
    for (int s = first; s <= last; s++) begin
      apply_stimulus(strobe_first && (s == first), base + 32'(s));
      if (bus.cap_valid === 1'b1) begin
        v_cnt++;
        v_slot = s;
        v_data = bus.cap_data;
      end
    end
  endtask

  // Pulse reset across one clock edge and return just after a rising edge.
  task automatic do_reset();
    bus.frame_strobe = 1'b0;
    #2 reset_n = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    v_data  = '0;
    reset_n = 1'b0;
    bus.frame_strobe = 1'b0;
    bus.data_in      = '0;
    bus.sel_index    = 3'd3;
    bus.sel_phase    = 2'd2;

    // Reset values.
    @(posedge clk);
    #1;
    check_output("rst_cap_data",  64'(bus.cap_data),     64'd0);
    check_output("rst_cap_valid", 64'(bus.cap_valid),    64'd0);
    check_output("rst_locked",    64'(bus.locked),       64'd0);
    check_output("rst_err",       64'(bus.sync_err_cnt), 64'd0);
    check_output("rst_slot",      64'(bus.slot_cnt_out), 64'd0);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // HUNT ignores cycles without a strobe.
    run_slots(0, 4, 1'b0, 32'd0);
    check_output("hunt_locked", 64'(bus.locked),       64'd0);
    check_output("hunt_slot",   64'(bus.slot_cnt_out), 64'd0);
    check_output("hunt_nocap",  64'(v_cnt),            64'd0);

    // Lock and capture at {3,2} = slot 14.
    run_slots(0, 0, 1'b1, 32'd0);
    check_output("lock_locked", 64'(bus.locked),       64'd1);
    check_output("lock_slot",   64'(bus.slot_cnt_out), 64'd1);
    run_slots(1, 31, 1'b0, 32'd0);
    check_output("f1_count", 64'(v_cnt),  64'd1);
    check_output("f1_slot",  64'(v_slot), 64'd14);
    check_output("f1_data",  64'(v_data), 64'd14);
    check_output("f1_wrap",  64'(bus.slot_cnt_out), 64'd0);
    run_slots(0, 31, 1'b1, 32'd0);
    check_output("f2_count", 64'(v_cnt),  64'd1);
    check_output("f2_slot",  64'(v_slot), 64'd14);
    check_output("f2_err",   64'(bus.sync_err_cnt), 64'd0);

    // Missing strobe drops lock; no capture until relock.
    run_slots(0, 31, 1'b0, 32'd0);
    check_output("miss_locked", 64'(bus.locked),       64'd0);
    check_output("miss_err",    64'(bus.sync_err_cnt), 64'd1);
    check_output("miss_count",  64'(v_cnt),            64'd0);
    check_output("miss_hold",   64'(bus.cap_data),     64'd14);
    run_slots(0, 31, 1'b1, 32'd0);
    check_output("relock_count",  64'(v_cnt),         64'd1);
    check_output("relock_locked", 64'(bus.locked),    64'd1);

    // Early strobe at counter 10 realigns and restarts the frame.
    do_reset();
    run_slots(0, 9, 1'b1, 32'd100);
    check_output("early_pre_count", 64'(v_cnt), 64'd0);
    run_slots(0, 0, 1'b1, 32'd200);
    check_output("early_slot",   64'(bus.slot_cnt_out), 64'd1);
    check_output("early_err",    64'(bus.sync_err_cnt), 64'd1);
    check_output("early_locked", 64'(bus.locked),       64'd1);
    run_slots(1, 31, 1'b0, 32'd200);
    check_output("early_count", 64'(v_cnt),  64'd1);
    check_output("early_data",  64'(v_data), 64'd214);
    run_slots(0, 19, 1'b1, 32'd300);
    check_output("pre_realign_data", 64'(v_data), 64'd314);
    run_slots(0, 31, 1'b1, 32'd400);
    check_output("recap_count", 64'(v_cnt),  64'd1);
    check_output("recap_data",  64'(v_data), 64'd414);
    check_output("recap_err",   64'(bus.sync_err_cnt), 64'd2);

    // Slot-0 selection captures on the locking strobe itself.
    bus.sel_index = 3'd0;
    bus.sel_phase = 2'd0;
    do_reset();
    run_slots(0, 0, 1'b1, 32'h55);
    check_output("s0_valid", 64'(bus.cap_valid), 64'd1);
    check_output("s0_data",  64'(bus.cap_data),  64'h55);
    run_slots(1, 31, 1'b0, 32'h55);
    check_output("s0_once", 64'(v_cnt), 64'd0);
    run_slots(0, 0, 1'b1, 32'h77);
    check_output("s0_locked_valid", 64'(bus.cap_valid), 64'd1);
    check_output("s0_locked_data",  64'(bus.cap_data),  64'h77);
    run_slots(1, 31, 1'b0, 32'd0);
    run_slots(0, 31, 1'b0, 32'h99);
    check_output("s0_miss_count", 64'(v_cnt),            64'd0);
    check_output("s0_miss_hold",  64'(bus.cap_data),     64'h77);
    check_output("s0_miss_err",   64'(bus.sync_err_cnt), 64'd1);

    // Mid-frame selection change applies from the next frame.
    bus.sel_index = 3'd3;
    bus.sel_phase = 2'd2;
    run_slots(0, 5, 1'b1, 32'd600);
    bus.sel_index = 3'd5;
    run_slots(6, 31, 1'b0, 32'd600);
    check_output("cfg_old_slot", 64'(v_slot), 64'd14);
    check_output("cfg_old_data", 64'(v_data), 64'd614);
    run_slots(0, 31, 1'b1, 32'd700);
    check_output("cfg_new_slot", 64'(v_slot), 64'd22);
    check_output("cfg_new_data", 64'(v_data), 64'd722);

    // Error counter saturation over 300 missing-strobe events.
    do_reset();
    for (int i = 0; i < 254; i++) run_slots(0, 32, 1'b1, 32'd0);
    check_output("sat_254", 64'(bus.sync_err_cnt), 64'd254);
    run_slots(0, 32, 1'b1, 32'd0);
    check_output("sat_255", 64'(bus.sync_err_cnt), 64'd255);
    for (int i = 0; i < 45; i++) run_slots(0, 32, 1'b1, 32'd0);
    check_output("sat_300",    64'(bus.sync_err_cnt), 64'd255);
    check_output("sat_locked", 64'(bus.locked),       64'd0);

    // Asynchronous reset mid-frame clears outputs without a clock edge.
    bus.sel_index = 3'd3;
    bus.sel_phase = 2'd2;
    run_slots(0, 19, 1'b1, 32'h800);
    check_output("pre_async_data", 64'(bus.cap_data),     64'h80E);
    check_output("pre_async_slot", 64'(bus.slot_cnt_out), 64'd20);
    bus.frame_strobe = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_output("async_cap_data", 64'(bus.cap_data),     64'd0);
    check_output("async_locked",   64'(bus.locked),       64'd0);
    check_output("async_err",      64'(bus.sync_err_cnt), 64'd0);
    check_output("async_slot",     64'(bus.slot_cnt_out), 64'd0);
    #2 reset_n = 1'b1;
    run_slots(0, 4, 1'b0, 32'd0);
    check_output("post_rst_locked", 64'(bus.locked),       64'd0);
    check_output("post_rst_slot",   64'(bus.slot_cnt_out), 64'd0);
    run_slots(0, 0, 1'b1, 32'd0);
    check_output("post_rst_relock", 64'(bus.locked),       64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_slot_demux.md
NEURON_SLOT_DEMUX -- requirements
Module: neuron_slot_demux

Interface
REQ-001 Parameter NN, default 8, neuron index width is NN+1 bits (2^(NN+1) neurons per frame).
REQ-002 Parameter DW, default 32, width of the multiplexed data bus.
REQ-003 clk  input  1  single clock; the block runs on the divided neuron clock; all logic is on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert and active-low.
REQ-005 frame_strobe  input  1  one-cycle pulse marking slot-counter value 0 of a frame.
REQ-006 data_in  input  DW  time-multiplexed neuron data; 4 cycles per neuron.
REQ-007 sel_index  input  NN+1  neuron to extract.
REQ-008 sel_phase  input  2  sub-cycle (0-3) within the neuron's 4-cycle slot at which data_in is sampled.
REQ-009 cap_data  output  DW  last captured value for the selected neuron.
REQ-010 cap_valid  output  1  one-cycle pulse when cap_data is updated.
REQ-011 locked  output  1  high while the block is aligned to the frame.
REQ-012 sync_err_cnt  output  8  saturating count of sync errors.
REQ-013 slot_cnt_out  output  NN+3  local slot counter, zero-extended; 0 while in HUNT.

Function
REQ-014 FSM states: HUNT and LOCKED. Reset state is HUNT.
REQ-015 Slot counter:
- NN+3 bits; frame length is 2^(NN+3) cycles.
- The current-cycle slot value is 0 on any cycle with frame_strobe high.
- Otherwise the value is the previous value + 1, wrapping modulo 2^(NN+3).
REQ-016 HUNT to LOCKED:
- Transition occurs on a cycle with frame_strobe=1.
- That cycle counts as slot 0, and the counter register is loaded with 1.
REQ-017 In HUNT, no capture occurs and frame_strobe=0 causes no state change.
REQ-018 LOCKED, correct alignment: frame_strobe=1 with the counter register at 0 -> no error; the counter advances to 1.
REQ-019 LOCKED, early strobe: frame_strobe=1 with the counter register not 0 -> realign (counter loads 1), stay LOCKED, sync_err_cnt increments.
REQ-020 LOCKED, missing strobe: frame_strobe=0 with the counter register at 0 -> go to HUNT, sync_err_cnt increments.
REQ-021 sync_err_cnt saturates at 255 and does not wrap.
REQ-022 Selection shadowing:
- sel_index and sel_phase are registered into shadow registers on each slot-0 cycle that is accepted as alignment (REQ-016, REQ-018, REQ-019).
- Mid-frame changes take effect next frame.
REQ-023 Capture condition: in LOCKED, or on the HUNT-to-LOCKED cycle, the current slot value equals {shadow_index, shadow_phase}.
- On the slot-0 cycle itself, the newly sampled sel values are used.
REQ-024 On a capture, cap_data <= data_in and cap_valid pulses high for exactly 1 cycle; both are registered with 1 cycle of latency after the sample cycle.
REQ-025 At most one capture occurs per frame.
- A realignment (REQ-019) restarts the frame.
- A capture may therefore occur again after a realignment.
REQ-026 cap_data holds its value between captures and while in HUNT.
REQ-027 locked = (state == LOCKED), registered.
REQ-028 The missing-strobe cycle (REQ-020) does not capture, even if the selected slot is 0.

Reset
REQ-029 While reset_n=0, all outputs are forced immediately:
- cap_data=0, cap_valid=0, locked=0, sync_err_cnt=0, slot_cnt_out=0.
- Shadow registers are 0 and the state is HUNT.
REQ-030 Reset mid-frame discards alignment; after release the block waits in HUNT for the next frame_strobe.
REQ-031 Reset release is synchronous to clk via the reset usage only; no output changes until the first rising edge after release.

Verification (NN=2: 8 neurons, 32-cycle frame)
REQ-032 Lock and capture:
- Stimulus: strobe every 32 cycles; data_in = slot number; sel_index=3, sel_phase=2.
- Response: locked=1 from the cycle after the first strobe; cap_valid pulses once per frame with cap_data=14, at 1-cycle latency.
REQ-033 Slot-0 capture:
- Stimulus: sel_index=0, sel_phase=0; first strobe arrives while in HUNT.
- Response: capture on that strobe cycle; cap_data=0.
REQ-034 Missing strobe:
- Stimulus: lock, then omit one strobe.
- Response: locked falls, sync_err_cnt=1, no cap_valid until the next strobe relocks.
REQ-035 Early strobe:
- Stimulus: while locked, assert strobe at counter value 10.
- Response: locked stays 1, sync_err_cnt=1, slot_cnt_out=1 on the next cycle, and the frame restarts from there.
REQ-036 Mid-frame reconfiguration and saturation:
- Stimulus: change sel_index mid-frame.
- Response: the capture position changes only from the next frame.
- Stimulus: 300 missing-strobe events.
- Response: sync_err_cnt=255.
REQ-037 Async reset:
- Stimulus: assert reset_n=0 mid-frame between clock edges.
- Response: outputs clear without waiting for a clock edge; after release the block stays in HUNT until a strobe.
